// File: rtl/filter_pkg.sv
// Shared constants and helpers for the 3x3 neighbourhood filter stages.
package filter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BYPASS = 2'b00;
    localparam mode_t MODE_BLUR   = 2'b01;
    localparam mode_t MODE_EDGE   = 2'b10;

    // Divide-by-9 approximated as (x*57)>>9.
    localparam int unsigned DIV9_MUL   = 57;
    localparam int unsigned DIV9_SHIFT = 9;

    // Sobel weights as shifts: corner taps x1, middle tap x2.
    localparam int unsigned SOBEL_SIDE_SHIFT = 0;
    localparam int unsigned SOBEL_MID_SHIFT  = 1;

    function automatic logic [31:0] sat(input logic [31:0] val, input logic [31:0] max_val);
        sat = (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-line pixel store: one read and one write per cycle, registered read,
// read-before-write on a shared address.
module line_buffer #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [PIX_W-1:0]  o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rd_data;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;

    // Callers only enable accesses for addresses below DEPTH.
    assign w_rd_idx  = i_rd_addr[IDX_W-1:0];
    assign w_wr_idx  = i_wr_addr[IDX_W-1:0];
    assign o_rd_data = r_rd_data;

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

endmodule

// File: rtl/window_filter.sv
// 3x3 window filter: bypass, box blur or Sobel edge magnitude, fixed 2-cycle
// latency in every mode so switching the stage never shifts the image.
module window_filter
    import filter_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned LINE_W = 640,
    parameter int unsigned COL_W  = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VSync,
    input  logic             HSync,
    input  logic [1:0]       Mode,
    input  logic             PixValid,
    input  logic [PIX_W-1:0] PixIn,
    output logic             OutValid,
    output logic [PIX_W-1:0] PixOut,
    output logic             HSyncOut
);

    localparam int unsigned SUM_W  = PIX_W + 4;
    localparam int unsigned PROD_W = SUM_W + 6;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(LINE_W);

    // Counters and mode latch
    logic [COL_W-1:0] r_col;
    logic [1:0]       r_row;
    mode_t            r_mode;

    logic [COL_W-1:0] w_col_cur;
    logic [1:0]       w_row_cur;
    logic             w_lb_en;

    always_comb begin
        w_col_cur = (VSync || HSync) ? '0 : r_col;
        if (VSync) begin
            w_row_cur = 2'd0;
        end else if (HSync && (r_row != 2'd3)) begin
            w_row_cur = r_row + 2'd1;
        end else begin
            w_row_cur = r_row;
        end
        w_lb_en = PixValid && (w_col_cur < COL_MAX);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_col  <= '0;
            r_row  <= 2'd0;
            r_mode <= MODE_BYPASS;
        end else begin
            r_row <= w_row_cur;
            if (PixValid && (w_col_cur != COL_MAX)) begin
                r_col <= w_col_cur + COL_W'(1);
            end else begin
                r_col <= w_col_cur;
            end
            if (VSync) begin
                r_mode <= Mode;
            end
        end
    end

    // Line buffers: lb1 holds row-1, lb2 holds row-2
    logic [PIX_W-1:0] w_lb1_rd;
    logic [PIX_W-1:0] w_lb2_rd;
    logic             r_lb2_we;
    logic [COL_W-1:0] r_col_s;
    logic [1:0]       r_row_s;

    line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (LINE_W),
        .ADDR_W(COL_W)
    ) u_lb1 (
        .CLK      (CLK),
        .RST      (RST),
        .i_rd_en  (w_lb_en),
        .i_rd_addr(w_col_cur),
        .o_rd_data(w_lb1_rd),
        .i_wr_en  (w_lb_en),
        .i_wr_addr(w_col_cur),
        .i_wr_data(PixIn)
    );

    // lb2 is written one cycle late, once lb1's old word has been read out.
    line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (LINE_W),
        .ADDR_W(COL_W)
    ) u_lb2 (
        .CLK      (CLK),
        .RST      (RST),
        .i_rd_en  (w_lb_en),
        .i_rd_addr(w_col_cur),
        .o_rd_data(w_lb2_rd),
        .i_wr_en  (r_lb2_we),
        .i_wr_addr(r_col_s),
        .i_wr_data(w_lb1_rd)
    );

    // Stage 1: window columns; index 0 = top row (lb2), 2 = bottom row (input)
    logic [2:0][PIX_W-1:0] r_c0;
    logic [2:0][PIX_W-1:0] r_c1;
    logic [2:0][PIX_W-1:0] w_c2;
    logic [PIX_W-1:0]      r_pix;
    logic                  r_v1;
    logic                  r_hs1;

    assign w_c2 = {r_pix, w_lb1_rd, w_lb2_rd};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_c0     <= '0;
            r_c1     <= '0;
            r_pix    <= '0;
            r_col_s  <= '0;
            r_row_s  <= 2'd0;
            r_v1     <= 1'b0;
            r_hs1    <= 1'b0;
            r_lb2_we <= 1'b0;
        end else begin
            r_v1     <= PixValid;
            r_hs1    <= HSync;
            r_lb2_we <= w_lb_en;
            if (PixValid) begin
                r_pix   <= PixIn;
                r_col_s <= w_col_cur;
                r_row_s <= w_row_cur;
                r_c0    <= r_c1;
                r_c1    <= w_c2;
            end
        end
    end

    // Stage 2: sum, scale, saturate, select
    logic [SUM_W-1:0]        w_sum;
    logic [PROD_W-1:0]       w_prod;
    logic [PIX_W-1:0]        w_blur;
    logic [SUM_W-1:0]        w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic signed [SUM_W-1:0] w_gx, w_gy;
    logic [SUM_W-1:0]        w_ax, w_ay, w_mag;
    logic [PIX_W-1:0]        w_edge;
    logic                    w_filt_ok;
    logic [PIX_W-1:0]        w_out;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 3; i++) begin
            w_sum = w_sum + SUM_W'(r_c0[i]) + SUM_W'(r_c1[i]) + SUM_W'(w_c2[i]);
        end
        w_prod = PROD_W'(w_sum) * PROD_W'(DIV9_MUL);
        w_blur = PIX_W'(sat(32'(w_prod >> DIV9_SHIFT), 32'(PIX_MAX)));

        w_gx_pos = (SUM_W'(w_c2[0]) << SOBEL_SIDE_SHIFT) + (SUM_W'(w_c2[1]) << SOBEL_MID_SHIFT)
                 + (SUM_W'(w_c2[2]) << SOBEL_SIDE_SHIFT);
        w_gx_neg = (SUM_W'(r_c0[0]) << SOBEL_SIDE_SHIFT) + (SUM_W'(r_c0[1]) << SOBEL_MID_SHIFT)
                 + (SUM_W'(r_c0[2]) << SOBEL_SIDE_SHIFT);
        w_gy_pos = (SUM_W'(r_c0[2]) << SOBEL_SIDE_SHIFT) + (SUM_W'(r_c1[2]) << SOBEL_MID_SHIFT)
                 + (SUM_W'(w_c2[2]) << SOBEL_SIDE_SHIFT);
        w_gy_neg = (SUM_W'(r_c0[0]) << SOBEL_SIDE_SHIFT) + (SUM_W'(r_c1[0]) << SOBEL_MID_SHIFT)
                 + (SUM_W'(w_c2[0]) << SOBEL_SIDE_SHIFT);
        w_gx  = $signed(w_gx_pos - w_gx_neg);
        w_gy  = $signed(w_gy_pos - w_gy_neg);
        w_ax  = (w_gx < 0) ? $unsigned(-w_gx) : $unsigned(w_gx);
        w_ay  = (w_gy < 0) ? $unsigned(-w_gy) : $unsigned(w_gy);
        w_mag = w_ax + w_ay;
        w_edge = PIX_W'(sat(32'(w_mag), 32'(PIX_MAX)));

        w_filt_ok = (r_row_s >= 2'd2) && (r_col_s >= COL_W'(2)) && (r_col_s < COL_MAX);

        w_out = '0;
        case (r_mode)
            MODE_BLUR: if (w_filt_ok) w_out = w_blur;
            MODE_EDGE: if (w_filt_ok) w_out = w_edge;
            default:   if ((r_row_s != 2'd0) && (r_col_s != '0)) w_out = r_c1[1];
        endcase
    end

    logic             r_out_valid;
    logic [PIX_W-1:0] r_pix_out;
    logic             r_hsync_out;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_valid <= 1'b0;
            r_pix_out   <= '0;
            r_hsync_out <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            r_hsync_out <= r_hs1;
            if (r_v1) begin
                r_pix_out <= w_out;
            end
        end
    end

    assign OutValid = r_out_valid;
    assign PixOut   = r_pix_out;
    assign HSyncOut = r_hsync_out;

endmodule

// File: tb/tb_window_filter.sv
// Directed vector bench for window_filter with LINE_W=8.
module tb_window_filter;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned LINE_W = 8;
    localparam int unsigned COL_W  = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             VSync = 1'b0;
    logic             HSync = 1'b0;
    logic [1:0]       Mode = 2'b00;
    logic             PixValid = 1'b0;
    logic [PIX_W-1:0] PixIn = '0;
    logic             OutValid;
    logic [PIX_W-1:0] PixOut;
    logic             HSyncOut;

    window_filter #(
        .PIX_W (PIX_W),
        .LINE_W(LINE_W),
        .COL_W (COL_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .VSync   (VSync),
        .HSync   (HSync),
        .Mode    (Mode),
        .PixValid(PixValid),
        .PixIn   (PixIn),
        .OutValid(OutValid),
        .PixOut  (PixOut),
        .HSyncOut(HSyncOut)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       vs;
        logic       hs;
        logic       pv;
        logic [7:0] pix;
        logic [1:0] mode;
        logic [7:0] eo;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic vs, input logic hs, input logic pv, input logic [7:0] pix,
                       input logic [1:0] mode, input logic [7:0] eo);
        vec_t v;
        v.vs = vs; v.hs = hs; v.pv = pv; v.pix = pix; v.mode = mode; v.eo = eo;
        vecs.push_back(v);
    endtask

    // Each vector's outputs are expected two cycles after it is applied.
    task automatic run(input string tag, input bit flush);
        int n = vecs.size() + (flush ? 2 : 0);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            if (i < vecs.size()) begin
                VSync = vecs[i].vs; HSync = vecs[i].hs; PixValid = vecs[i].pv;
                PixIn = vecs[i].pix; Mode = vecs[i].mode;
            end else begin
                VSync = 1'b0; HSync = 1'b0; PixValid = 1'b0;
            end
            @(negedge CLK);
            if (i >= 2) begin
                check($sformatf("%s[%0d] valid", tag, i - 2), 32'(OutValid), 32'(vecs[i-2].pv));
                check($sformatf("%s[%0d] hsync", tag, i - 2), 32'(HSyncOut), 32'(vecs[i-2].hs));
                if (vecs[i-2].pv) begin
                    check($sformatf("%s[%0d] pix", tag, i - 2), 32'(PixOut), 32'(vecs[i-2].eo));
                end
            end
        end
        vecs.delete();
    endtask

    function automatic logic [7:0] step_pix(input int c);
        return (c >= 4) ? 8'd255 : 8'd0;
    endfunction

    function automatic logic [7:0] step_exp(input int r, input int c);
        return (r >= 2 && (c == 4 || c == 5)) ? 8'd255 : 8'd0;
    endfunction

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset valid", 32'(OutValid), 0);
        check("reset pix", 32'(PixOut), 0);
        check("reset hsync", 32'(HSyncOut), 0);
        RST = 1'b1;

        // Flat frame, blur: interior (900*57)>>9 = 100, border 0
        add(1, 0, 0, 0, 2'b01, 0);
        for (int r = 0; r < 4; r++) begin
            if (r > 0) add(0, 1, 0, 0, 2'b01, 0);
            for (int c = 0; c < 8; c++) add(0, 0, 1, 100, 2'b01, (r >= 2 && c >= 2) ? 8'd100 : 8'd0);
        end
        run("flat", 1);

        // Vertical step, Sobel, HSync coincident with the first pixel
        add(1, 0, 0, 0, 2'b10, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                add(0, (r > 0 && c == 0), 1, step_pix(c), 2'b10, step_exp(r, c));
        run("edge", 1);

        // Bypass ramp; Mode input changes mid-frame and must be ignored
        add(1, 0, 0, 0, 2'b00, 0);
        for (int r = 0; r < 4; r++) begin
            if (r > 0) add(0, 1, 0, 0, (r >= 2) ? 2'b01 : 2'b00, 0);
            for (int c = 0; c < 8; c++)
                add(0, 0, 1, 8'(c + 16 * r), (r >= 2) ? 2'b01 : 2'b00,
                    (r >= 1 && c >= 1) ? 8'((c - 1) + 16 * (r - 1)) : 8'd0);
        end
        // Next VSync latches blur: rows 0-1 now fully masked
        add(1, 0, 0, 0, 2'b01, 0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++) add(0, (r > 0 && c == 0), 1, 8'(c + 16 * r), 2'b01, 0);
        run("bypass", 1);

        // Step edge with PixValid 1010...
        add(1, 0, 0, 0, 2'b10, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                add(0, (r > 0 && c == 0), 1, step_pix(c), 2'b10, step_exp(r, c));
                add(0, 0, 0, 8'd77, 2'b10, 0);
            end
        run("gaps", 1);

        // Overlong line: extra pixels output 0 and must not reach the buffers
        add(1, 0, 0, 0, 2'b01, 0);
        for (int r = 0; r < 4; r++) begin
            int len = (r == 2) ? 10 : 8;
            for (int c = 0; c < len; c++)
                add(0, (r > 0 && c == 0), 1, (c >= 8) ? 8'd200 : 8'd100, 2'b01,
                    (r >= 2 && c >= 2 && c < 8) ? 8'd100 : 8'd0);
        end
        run("overflow", 1);

        // Mid-line asynchronous reset
        add(1, 0, 0, 0, 2'b00, 0);
        for (int r = 0; r < 3; r++) begin
            int len = (r == 2) ? 5 : 8;
            if (r > 0) add(0, 1, 0, 0, 2'b00, 0);
            for (int c = 0; c < len; c++)
                add(0, 0, 1, 8'(c + 16 * r), 2'b00,
                    (r >= 1 && c >= 1) ? 8'((c - 1) + 16 * (r - 1)) : 8'd0);
        end
        run("prerst", 0);
        #2;
        RST = 1'b0;
        PixValid = 1'b0;
        #1;
        check("async rst valid", 32'(OutValid), 0);
        check("async rst pix", 32'(PixOut), 0);
        check("async rst hsync", 32'(HSyncOut), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // After reset mode_q is bypass and row 0 is masked until an HSync
        for (int r = 0; r < 3; r++) begin
            if (r > 0) add(0, 1, 0, 0, 2'b01, 0);
            for (int c = 0; c < 8; c++) add(0, 0, 1, 100, 2'b01, (r >= 1 && c >= 1) ? 8'd100 : 8'd0);
        end
        run("postrst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
